// File: rtl/fft_ctrl_pkg.sv
// Shared definitions for the FFT stage controller: default geometry,
// watchdog limit and the FSM state encoding.
package fft_ctrl_pkg;

  localparam int N_LOG2_DEF  = 5;
  localparam int N_DEF       = 1 << N_LOG2_DEF;
  localparam int TIMEOUT_DEF = 63;

  localparam logic [2:0] ST_IDLE_ENC  = 3'd0;
  localparam logic [2:0] ST_READ_ENC  = 3'd1;
  localparam logic [2:0] ST_MULT_ENC  = 3'd2;
  localparam logic [2:0] ST_WRITE_ENC = 3'd3;
  localparam logic [2:0] ST_DONE_ENC  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_READ  = ST_READ_ENC,
    ST_MULT  = ST_MULT_ENC,
    ST_WRITE = ST_WRITE_ENC,
    ST_DONE  = ST_DONE_ENC
  } state_t;

endpackage

// File: rtl/fft_addr_gen.sv
// Radix-2 DIT butterfly address generator: maps (stage s, butterfly j) to
// the two sample-RAM legs and the twiddle-ROM index. Purely combinational.
module fft_addr_gen
  import fft_ctrl_pkg::*;
#(
  parameter int N_LOG2 = N_LOG2_DEF
) (
  input  logic [2:0]        i_stage,
  input  logic [N_LOG2-2:0] i_j,
  output logic [N_LOG2-1:0] o_addr_a,
  output logic [N_LOG2-1:0] o_addr_b,
  output logic [N_LOG2-2:0] o_tw_idx
);

  localparam logic [2:0] S_MAX = 3'(N_LOG2 - 1);

  logic [N_LOG2-1:0] j_w;
  logic [N_LOG2-1:0] half;
  logic [N_LOG2-1:0] mask;
  logic [N_LOG2-1:0] pos;

  // Group bits of j move up one place to open a hole at bit s; the
  // bottom leg fills that hole, so addr_b is addr_a with bit s set.
  always_comb begin
    j_w      = {1'b0, i_j};
    half     = N_LOG2'(1) << i_stage;
    mask     = half - N_LOG2'(1);
    pos      = j_w & mask;
    o_addr_a = ((j_w & ~mask) << 1) | pos;
    o_addr_b = o_addr_a | half;
    o_tw_idx = pos[N_LOG2-2:0] << (S_MAX - i_stage);
  end

endmodule

// File: rtl/fft_stage_sequencer.sv
// Control FSM for one radix-2 DIT pass: walks all N/2 butterflies of the
// selected stage, issues read / multiply / write strobes and watchdogs the
// iterative twiddle multiplier.
module fft_stage_sequencer
  import fft_ctrl_pkg::*;
#(
  parameter int N_LOG2  = N_LOG2_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_stage_start,
  input  logic [2:0]        i_stage,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic              o_rd_en,
  output logic [N_LOG2-1:0] o_addr_a,
  output logic [N_LOG2-1:0] o_addr_b,
  output logic [N_LOG2-2:0] o_tw_idx,
  output logic              o_mult_start,
  input  logic              i_mult_valid,
  output logic              o_wr_en
);

  localparam int JW  = N_LOG2 - 1;
  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [JW-1:0]  J_LAST  = {JW{1'b1}};
  // Watchdog holds the number of MULT cycles already spent, so the
  // TIMEOUT-th MULT cycle is the one that sees TIMEOUT-1.
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [2:0]         s_q, s_d;
  logic [JW-1:0]      j_q, j_d;
  logic [WDW-1:0]     wd_q, wd_d;
  logic               error_q, error_d;
  logic [N_LOG2-1:0]  addr_a_q, addr_a_d;
  logic [N_LOG2-1:0]  addr_b_q, addr_b_d;
  logic [N_LOG2-2:0]  tw_q, tw_d;
  logic [N_LOG2-1:0]  gen_a, gen_b;
  logic [N_LOG2-2:0]  gen_tw;
  logic               stage_ok;

  // Addresses are generated from the next-state stage/index so they are
  // already registered in the first READ cycle of each butterfly.
  fft_addr_gen #(
    .N_LOG2 (N_LOG2)
  ) u_addr_gen (
    .i_stage  (s_d),
    .i_j      (j_d),
    .o_addr_a (gen_a),
    .o_addr_b (gen_b),
    .o_tw_idx (gen_tw)
  );

  assign stage_ok = ({29'd0, i_stage} < 32'(N_LOG2));

  // Next-state, counters, sticky error and address capture.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    j_d     = j_q;
    wd_d    = wd_q;
    error_d = error_q;
    case (state_q)
      ST_IDLE: begin
        if (i_stage_start) begin
          if (stage_ok) begin
            s_d     = i_stage;
            j_d     = '0;
            error_d = 1'b0;
            state_d = ST_READ;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      ST_READ: begin
        wd_d    = '0;
        state_d = ST_MULT;
      end
      ST_MULT: begin
        if (i_mult_valid) begin
          state_d = ST_WRITE;
        end else if (wd_q == WD_LAST) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      ST_WRITE: begin
        if (j_q == J_LAST) begin
          state_d = ST_DONE;
        end else begin
          j_d     = j_q + JW'(1);
          state_d = ST_READ;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    tw_d     = tw_q;
    if (state_d == ST_READ) begin
      addr_a_d = gen_a;
      addr_b_d = gen_b;
      tw_d     = gen_tw;
    end
  end

  // State and control registers; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      s_q      <= '0;
      j_q      <= '0;
      wd_q     <= '0;
      error_q  <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      tw_q     <= '0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      j_q      <= j_d;
      wd_q     <= wd_d;
      error_q  <= error_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      tw_q     <= tw_d;
    end
  end

  assign o_busy       = (state_q != ST_IDLE);
  assign o_rd_en      = (state_q == ST_READ);
  assign o_mult_start = (state_q == ST_MULT);
  assign o_wr_en      = (state_q == ST_WRITE);
  assign o_done       = (state_q == ST_DONE);
  assign o_error      = error_q;
  assign o_addr_a     = addr_a_q;
  assign o_addr_b     = addr_b_q;
  assign o_tw_idx     = tw_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer with a multiplier latency model
// and an address scoreboard fed from an independent butterfly formula.
module tb_fft_stage_sequencer;

  localparam int NL = 5;
  localparam int NH = 16;

  typedef struct packed {
    logic [4:0] a;
    logic [4:0] b;
    logic [3:0] tw;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_stage_start;
  logic [2:0] i_stage;
  logic       i_mult_valid;
  logic       o_busy, o_done, o_error, o_rd_en, o_mult_start, o_wr_en;
  logic [4:0] o_addr_a, o_addr_b;
  logic [3:0] o_tw_idx;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mult_lat;
  int   mcnt;
  int   wr_cnt;
  int   done_cnt;
  int   overlap;
  logic [31:0] cov;
  exp_t sb[$];

  fft_stage_sequencer #(.N_LOG2(NL), .TIMEOUT(63)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_stage_start (i_stage_start),
    .i_stage       (i_stage),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_error       (o_error),
    .o_rd_en       (o_rd_en),
    .o_addr_a      (o_addr_a),
    .o_addr_b      (o_addr_b),
    .o_tw_idx      (o_tw_idx),
    .o_mult_start  (o_mult_start),
    .i_mult_valid  (i_mult_valid),
    .o_wr_en       (o_wr_en)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int s, input int j);
    int half, pos, a;
    exp_t e;
    half = 1 << s;
    pos  = j % half;
    a    = (j / half) * 2 * half + pos;
    e.a  = 5'(a);
    e.b  = 5'(a + half);
    e.tw = 4'(pos * (NH / half));
    return e;
  endfunction

  task automatic push_stage(input int s);
    for (int j = 0; j < NH; j++) sb.push_back(model(s, j));
  endtask

  task automatic run_stage(input int s, input int lat, input int exp_done, input int inject);
    int start_cyc, wr_base, done_rel;
    bit seen;
    mult_lat = lat;
    @(posedge clk); #1;
    chk("idle_busy", o_busy, 0);
    i_stage_start = 1'b1;
    i_stage       = 3'(s);
    start_cyc     = cyc;
    wr_base       = wr_cnt;
    push_stage(s);
    @(posedge clk); #1;
    i_stage_start = 1'b0;
    i_stage       = 3'd0;
    chk("c1_busy", o_busy, 1);
    chk("c1_rd_en", o_rd_en, 1);
    chk("c1_error", o_error, 0);
    seen = 0;
    done_rel = -1;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (o_done) begin
        seen = 1;
        done_rel = cyc - start_cyc;
        break;
      end
      @(posedge clk); #1;
      i_stage_start = (inject != 0) && ((cyc - start_cyc) == inject);
    end
    i_stage_start = 1'b0;
    #1;
    chk("done_seen", 32'(seen), 1);
    chk("done_cycle", done_rel, exp_done);
    chk("wr_pulses", wr_cnt - wr_base, NH);
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    int base_wr, base_done, st_cyc, err_rel;
    reset = 1'b1; i_stage_start = 1'b0; i_stage = 3'd0; i_mult_valid = 1'b0;
    mult_lat = 3; mcnt = 0; wr_cnt = 0; done_cnt = 0; overlap = 0; cov = '0;

    // Monitor / scoreboard and multiplier latency model, on the falling edge.
    fork
      forever begin
        @(negedge clk);
        if (!reset) begin
          if (!o_busy) begin
            cov = '0;
            overlap = 0;
          end
          if (o_rd_en) begin
            chk("rd_sb_nonempty", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
              chk("rd_addr_a", o_addr_a, sb[0].a);
              chk("rd_addr_b", o_addr_b, sb[0].b);
              chk("rd_tw", o_tw_idx, sb[0].tw);
            end
          end
          if (o_wr_en) begin
            exp_t e;
            wr_cnt++;
            chk("wr_sb_nonempty", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
              e = sb.pop_front();
              chk("wr_addr_a", o_addr_a, e.a);
              chk("wr_addr_b", o_addr_b, e.b);
              chk("wr_tw", o_tw_idx, e.tw);
            end
            if ((cov & (32'd1 << o_addr_a)) != 0) overlap++;
            if ((cov & (32'd1 << o_addr_b)) != 0) overlap++;
            cov = cov | (32'd1 << o_addr_a) | (32'd1 << o_addr_b);
          end
          if (o_done) done_cnt++;
        end
        if (o_mult_start) begin
          mcnt++;
          i_mult_valid = (mult_lat != 0) && (mcnt == mult_lat);
        end else begin
          mcnt = 0;
          i_mult_valid = 1'b0;
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_error", o_error, 0);
    chk("rst_rd_en", o_rd_en, 0);
    chk("rst_mult_start", o_mult_start, 0);
    chk("rst_wr_en", o_wr_en, 0);
    chk("rst_addr_a", o_addr_a, 0);
    chk("rst_addr_b", o_addr_b, 0);
    chk("rst_tw", o_tw_idx, 0);
    reset = 1'b0;

    run_stage(0, 3, 81, 0);
    run_stage(2, 3, 81, 0);
    chk("s2_coverage", cov, 32'hFFFF_FFFF);
    chk("s2_overlap", overlap, 0);

    @(posedge clk); #1;
    i_stage_start = 1'b1; i_stage = 3'd5;
    @(posedge clk); #1;
    i_stage_start = 1'b0; i_stage = 3'd0;
    chk("bad_stage_busy", o_busy, 0);
    chk("bad_stage_error", o_error, 1);
    chk("bad_stage_rd_en", o_rd_en, 0);
    @(posedge clk); #1;
    chk("bad_stage_busy2", o_busy, 0);
    chk("bad_stage_error2", o_error, 1);

    run_stage(4, 1, 49, 0);

    // Multiplier that never answers: watchdog abort.
    mult_lat = 0;
    @(posedge clk); #1;
    i_stage_start = 1'b1; i_stage = 3'd1;
    st_cyc = cyc; base_wr = wr_cnt; base_done = done_cnt;
    sb.push_back(model(1, 0));
    @(posedge clk); #1;
    i_stage_start = 1'b0; i_stage = 3'd0;
    err_rel = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (o_error) begin
        err_rel = cyc - st_cyc;
        break;
      end
    end
    #1;
    chk("to_error_cycle", err_rel, 65);
    chk("to_error", o_error, 1);
    chk("to_busy", o_busy, 0);
    chk("to_mult_start", o_mult_start, 0);
    chk("to_no_wr", wr_cnt - base_wr, 0);
    chk("to_no_done", done_cnt - base_done, 0);
    sb.delete();

    // Reset during MULT of butterfly 7.
    mult_lat = 3;
    @(posedge clk); #1;
    i_stage_start = 1'b1; i_stage = 3'd1;
    base_wr = wr_cnt;
    push_stage(1);
    @(posedge clk); #1;
    i_stage_start = 1'b0; i_stage = 3'd0;
    err_rel = -1;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (o_mult_start && (wr_cnt - base_wr) == 7) begin
        err_rel = k;
        break;
      end
    end
    chk("mr_reached_bf7", 32'(err_rel >= 0), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("mr_busy", o_busy, 0);
    chk("mr_done", o_done, 0);
    chk("mr_error", o_error, 0);
    chk("mr_rd_en", o_rd_en, 0);
    chk("mr_mult_start", o_mult_start, 0);
    chk("mr_wr_en", o_wr_en, 0);
    chk("mr_addr_a", o_addr_a, 0);
    chk("mr_addr_b", o_addr_b, 0);
    chk("mr_tw", o_tw_idx, 0);
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mr_no_write", wr_cnt - base_wr, 7);

    run_stage(1, 3, 81, 0);
    run_stage(3, 2, 65, 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
